// File: rtl/fp_pkg.sv
// Shared floating-point types and constants for the fp datapath.
// Widths are generic; constants are built as 64-bit words and sliced.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_inf(
    input int exp_w,
    input int man_w
  );
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return ones << man_w;
  endfunction

  function automatic logic [63:0] fp_qnan(
    input int exp_w,
    input int man_w
  );
    return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_zero(
    input logic sign,
    input int   exp_w,
    input int   man_w
  );
    return 64'(sign) << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Field split and classification of one operand.
// Denormals classify as zero (flush-to-zero).
module fp_unpack
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic [W-1:0]     op_i,
  output logic             sign_o,
  output logic [EXP_W-1:0] exp_o,
  output logic [MAN_W:0]   sig_o,
  output fp_class_e        cls_o
);

  logic [MAN_W-1:0] man;
  logic             exp_zero;
  logic             exp_ones;
  logic             man_nz;

  assign sign_o   = op_i[W-1];
  assign exp_o    = op_i[W-2:MAN_W];
  assign man      = op_i[MAN_W-1:0];
  assign exp_zero = ~|exp_o;
  assign exp_ones = &exp_o;
  assign man_nz   = |man;
  assign sig_o    = {1'b1, man};

  always_comb begin
    cls_o = FP_NORM;
    unique case (1'b1)
      exp_zero:            cls_o = FP_ZERO;
      exp_ones && man_nz:  cls_o = FP_NAN;
      exp_ones && !man_nz: cls_o = FP_INF;
      default:             cls_o = FP_NORM;
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined FP multiplier, RNE rounding, flush-to-zero.
// Stages: classify, multiply, normalise/round/pack; one global enable.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_operand,
  input  logic [W-1:0] b_operand,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         invalid,
  output logic         overflow,
  output logic         underflow
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;

  localparam logic [63:0] QNAN64 = fp_qnan(EXP_W, MAN_W);
  localparam logic [63:0] INF64  = fp_inf(EXP_W, MAN_W);
  localparam logic [63:0] ZERO64 = fp_zero(1'b0, EXP_W, MAN_W);

  localparam logic [W-1:0] QNAN  = QNAN64[W-1:0];
  localparam logic [W-2:0] INF_M = INF64[W-2:0];
  localparam logic [W-2:0] ZER_M = ZERO64[W-2:0];

  localparam logic signed [EW-1:0] BIAS_S =
    EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX_S =
    EW'((1 << EXP_W) - 1);

  logic adv;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv & rst_n;

  logic             ua_sign, ub_sign;
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [MAN_W:0]   ua_sig, ub_sig;
  fp_class_e        ua_cls, ub_cls;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unp_a (
    .op_i   (a_operand),
    .sign_o (ua_sign),
    .exp_o  (ua_exp),
    .sig_o  (ua_sig),
    .cls_o  (ua_cls)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unp_b (
    .op_i   (b_operand),
    .sign_o (ub_sign),
    .exp_o  (ub_exp),
    .sig_o  (ub_sig),
    .cls_o  (ub_cls)
  );

  // S1: resolve the pair into one product class (ordered priority)
  fp_class_e              s1_cls_d;
  logic signed [EW-1:0]   s1_exp_d;
  logic                   a_inf0, b_inf0;

  assign a_inf0 = (ua_cls == FP_INF) && (ub_cls == FP_ZERO);
  assign b_inf0 = (ub_cls == FP_INF) && (ua_cls == FP_ZERO);
  assign s1_exp_d = $signed({2'b00, ua_exp})
                  + $signed({2'b00, ub_exp});

  always_comb begin
    s1_cls_d = FP_NORM;
    if (ua_cls == FP_NAN || ub_cls == FP_NAN || a_inf0 || b_inf0)
      s1_cls_d = FP_NAN;
    else if (ua_cls == FP_INF || ub_cls == FP_INF)
      s1_cls_d = FP_INF;
    else if (ua_cls == FP_ZERO || ub_cls == FP_ZERO)
      s1_cls_d = FP_ZERO;
  end

  logic                 s1_valid_q, s2_valid_q;
  logic                 s1_sign_q, s2_sign_q;
  fp_class_e            s1_cls_q, s2_cls_q;
  logic signed [EW-1:0] s1_exp_q, s2_exp_q;
  logic [MAN_W:0]       s1_siga_q, s1_sigb_q;
  logic [PW-1:0]        s2_prod_d, s2_prod_q;

  assign s2_prod_d = {{(MAN_W+1){1'b0}}, s1_siga_q}
                   * {{(MAN_W+1){1'b0}}, s1_sigb_q};

  // S3: normalise, round to nearest even, pack
  logic                 msb;
  logic [PW-3:0]        norm;
  logic                 guard, sticky, inc;
  logic [MAN_W:0]       rnd;
  logic signed [EW-1:0] exp_r;
  logic                 ovf, unf;
  logic [W-1:0]         result_d, result_q;
  fp_flags_t            flags_d, flags_q;
  logic                 out_valid_q;

  assign msb    = s2_prod_q[PW-1];
  assign norm   = msb ? s2_prod_q[PW-2:1] : s2_prod_q[PW-3:0];
  assign guard  = norm[MAN_W-1];
  assign sticky = |norm[MAN_W-2:0] | (msb & s2_prod_q[0]);
  assign inc    = guard & (sticky | norm[MAN_W]);
  assign rnd    = {1'b0, norm[PW-3:MAN_W]}
                + {{MAN_W{1'b0}}, inc};
  assign exp_r  = s2_exp_q
                + $signed({{(EW-1){1'b0}}, msb})
                + $signed({{(EW-1){1'b0}}, rnd[MAN_W]})
                - BIAS_S;
  assign ovf    = exp_r >= EMAX_S;
  assign unf    = exp_r[EW-1] || (exp_r == '0);

  always_comb begin
    result_d = '0;
    flags_d  = '0;
    unique case (s2_cls_q)
      FP_NAN: begin
        result_d        = QNAN;
        flags_d.invalid = 1'b1;
      end
      FP_INF:  result_d = {s2_sign_q, INF_M};
      FP_ZERO: result_d = {s2_sign_q, ZER_M};
      default: begin
        unique case (1'b1)
          ovf: begin
            result_d         = {s2_sign_q, INF_M};
            flags_d.overflow = 1'b1;
          end
          unf: begin
            result_d          = {s2_sign_q, ZER_M};
            flags_d.underflow = 1'b1;
          end
          default: result_d = {s2_sign_q,
                               exp_r[EXP_W-1:0],
                               rnd[MAN_W-1:0]};
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_cls_q    <= FP_ZERO;
      s1_exp_q    <= '0;
      s1_siga_q   <= '0;
      s1_sigb_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= FP_ZERO;
      s2_exp_q    <= '0;
      s2_prod_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_sign_q   <= ua_sign ^ ub_sign;
      s1_cls_q    <= s1_cls_d;
      s1_exp_q    <= s1_exp_d;
      s1_siga_q   <= ua_sig;
      s1_sigb_q   <= ub_sig;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_cls_q    <= s1_cls_q;
      s2_exp_q    <= s1_exp_q;
      s2_prod_q   <= s2_prod_d;
      out_valid_q <= s2_valid_q;
      result_q    <= s2_valid_q ? result_d : '0;
      flags_q     <= s2_valid_q ? flags_d : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign invalid   = flags_q.invalid;
  assign overflow  = flags_q.overflow;
  assign underflow = flags_q.underflow;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed cases, stall, reset, random stream.
// Expected values come from an integer model of FP32 multiplication.
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        invalid;
  logic        overflow;
  logic        underflow;

  fp_mul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .invalid   (invalid),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  logic [34:0] sb[$];

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {invalid, overflow, underflow, result}
  function automatic logic [34:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b
  );
    int      ea, eb, e, k;
    longint  ma, mb, p, q, rem, half;
    logic    s, an, bn, ai, bi, az, bz;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (ma != 0);
    bn = (eb == 255) && (mb != 0);
    ai = (ea == 255) && (ma == 0);
    bi = (eb == 255) && (mb == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az))
      return {3'b100, 32'h7FC0_0000};
    if (ai || bi)
      return {3'b000, s, 8'hFF, 23'h0};
    if (az || bz)
      return {3'b000, s, 31'h0};
    p = (ma + 64'h80_0000) * (mb + 64'h80_0000);
    k = (p >= (64'sd1 <<< 47)) ? 24 : 23;
    q = p >>> k;
    rem  = p - (q <<< k);
    half = 64'sd1 <<< (k - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'sd1 <<< 24)) begin
      q = q >>> 1;
      k = k + 1;
    end
    e = ea + eb - 127 + (k - 23);
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, s, 31'h0};
    return {3'b000, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    int unsigned r;
    logic        s;
    logic [22:0] m;
    r = $urandom_range(0, 15);
    s = 1'($urandom);
    m = 23'($urandom);
    case (r)
      0:       return {s, 31'h0};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, m | 23'h1};
      3:       return {s, 8'h00, m};
      4:       return {s, 8'($urandom_range(1, 254)), 23'h7FFFFF};
      5:       return 32'($urandom);
      default: return {s, 8'($urandom_range(60, 194)), m};
    endcase
  endfunction

  // Drive one cycle at the falling edge, then observe both handshakes.
  task automatic tick(
    input  logic        iv,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [34:0] e,
    input  logic        ordy,
    output logic        acc,
    output logic        fired
  );
    logic [34:0] exp;
    @(negedge clk);
    in_valid  = iv;
    a_operand = a;
    b_operand = b;
    out_ready = ordy;
    #1;
    acc   = iv && in_ready;
    fired = out_valid && out_ready;
    if (acc) sb.push_back(e);
    if (fired) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("spurious_out", 64'(1), 64'(0));
      end else begin
        exp = sb.pop_front();
        chk("result",
            64'({invalid, overflow, underflow, result}),
            64'(exp));
      end
    end
  endtask

  task automatic idle(input int n);
    logic acc, fired;
    for (int i = 0; i < n; i++)
      tick(1'b0, '0, '0, '0, 1'b1, acc, fired);
  endtask

  task automatic lat_test(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [34:0] e
  );
    int   n;
    logic acc, fired;
    tick(1'b1, a, b, e, 1'b1, acc, fired);
    chk("lat_accept", 64'(acc), 64'(1));
    n     = 0;
    fired = 1'b0;
    while (!fired && n < 10) begin
      tick(1'b0, '0, '0, '0, 1'b1, acc, fired);
      n++;
    end
    chk("latency", 64'(n), 64'(3));
  endtask

  logic [31:0] da[10] = '{
    32'h3FC00000, 32'hBFC00000, 32'h3F800001, 32'h3FFFFFFF,
    32'h7F000000, 32'h00800000, 32'h80000000, 32'h7F800000,
    32'h7FC00001, 32'hFF800000};
  logic [31:0] db[10] = '{
    32'h40000000, 32'h40000000, 32'h3F800001, 32'h3FFFFFFF,
    32'h7F000000, 32'h00800000, 32'h3F800000, 32'h00000000,
    32'h3F800000, 32'h40000000};
  logic [34:0] de[10] = '{
    {3'b000, 32'h40400000}, {3'b000, 32'hC0400000},
    {3'b000, 32'h3F800002}, {3'b000, 32'h407FFFFE},
    {3'b010, 32'h7F800000}, {3'b001, 32'h00000000},
    {3'b000, 32'h80000000}, {3'b100, 32'h7FC00000},
    {3'b100, 32'h7FC00000}, {3'b000, 32'hFF800000}};

  initial begin
    logic        acc, fired;
    logic [31:0] a, b, held;
    logic [31:0] pa[5], pb[5];
    int          idx, base;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_operand = '0;
    b_operand = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_out",
        64'({invalid, overflow, underflow, result}), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Directed cases; first one also measures latency
    lat_test(da[0], db[0], de[0]);
    for (int i = 1; i < 10; i++) begin
      tick(1'b1, da[i], db[i], de[i], 1'b1, acc, fired);
      chk("dir_accept", 64'(acc), 64'(1));
    end
    idle(6);
    chk("dir_drain", 64'(sb.size()), 64'(0));

    // Backpressure: 5 back-to-back pairs, consumer stalls cycles 4-8
    for (int i = 0; i < 5; i++) begin
      pa[i] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
      pb[i] = {1'($urandom), 8'($urandom_range(100, 150)),
               23'($urandom)};
    end
    idx  = 0;
    base = n_out;
    held = '0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 5)
        tick(1'b1, pa[idx], pb[idx], ref_mul(pa[idx], pb[idx]),
             !(c >= 4 && c <= 8), acc, fired);
      else
        tick(1'b0, '0, '0, '0, !(c >= 4 && c <= 8), acc, fired);
      if (acc) idx++;
      if (c >= 4 && c <= 8)
        chk("stall_in_ready", 64'(in_ready), 64'(0));
      if (c == 4) held = result;
      if (c >= 5 && c <= 8)
        chk("stall_hold", 64'(result), 64'(held));
    end
    chk("bp_delivered", 64'(n_out - base), 64'(5));
    chk("bp_drain", 64'(sb.size()), 64'(0));

    // Asynchronous reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      a = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
      b = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
      tick(1'b1, a, b, ref_mul(a, b), 1'b0, acc, fired);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_out",
        64'({invalid, overflow, underflow, result}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    base = n_out;
    idle(6);
    chk("no_stale", 64'(n_out - base), 64'(0));
    lat_test(32'h40400000, 32'h40A00000,
             {3'b000, 32'h41700000});
    idle(2);

    // Random stream with random stalls on both sides
    a = rnd_op();
    b = rnd_op();
    for (int c = 0; c < 4000; c++) begin
      tick($urandom_range(0, 3) != 0, a, b, ref_mul(a, b),
           $urandom_range(0, 3) != 0, acc, fired);
      if (acc) begin
        a = rnd_op();
        b = rnd_op();
      end
    end
    idle(8);
    chk("rand_drain", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
